// File: rtl/steer_quad_multi_if.sv
// Steering bus between the joystick merge logic and the quadrature encoder.
// No handshake: requests are level-sampled every clock, outputs are registered levels/strobes.
interface steer_quad_multi_if #(
    parameter int CHANNELS = 2,
    parameter int DIV_W    = 16
);
    logic [DIV_W-1:0]      clkdiv;
    logic                  accel_en;
    logic [CHANNELS-1:0]   left;
    logic [CHANNELS-1:0]   right;
    logic [2*CHANNELS-1:0] steer;
    logic [CHANNELS-1:0]   step_pulse;
    logic [8*CHANNELS-1:0] pos;
    logic [2*CHANNELS-1:0] state_dbg;

    modport master (
        output clkdiv, accel_en, left, right,
        input  steer, step_pulse, pos, state_dbg
    );

    modport slave (
        input  clkdiv, accel_en, left, right,
        output steer, step_pulse, pos, state_dbg
    );
endinterface

// File: rtl/steer_quad_multi.sv
// Multi-channel joystick-to-quadrature steering encoder with per-channel
// step-rate acceleration, step strobe and signed 8-bit position counter.
module steer_quad_multi #(
    parameter int CHANNELS    = 2,
    parameter int DIV_W       = 16,
    parameter int ACCEL_STEPS = 4,
    parameter int ACCEL_HOLD  = 8
) (
    input logic               CLK,
    input logic               reset,
    steer_quad_multi_if.slave bus
);
    localparam int LVL_W  = (ACCEL_STEPS > 1) ? $clog2(ACCEL_STEPS) : 1;
    localparam int HOLD_W = $clog2(ACCEL_HOLD + 1);
    localparam logic [LVL_W-1:0]  TOP_LVL  = LVL_W'(ACCEL_STEPS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACCEL_HOLD);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_R = 2'd1,
        RUN_L = 2'd2
    } state_t;

    logic [CHANNELS-1:0][1:0] phase_a;
    logic [CHANNELS-1:0][7:0] pos_a;
    logic [CHANNELS-1:0][1:0] state_a;
    logic [CHANNELS-1:0]      step_a;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic              l_q, r_q;
        state_t            state, state_nx;
        logic [DIV_W-1:0]  cnt, cnt_nx, eff, per_m1;
        logic [LVL_W-1:0]  level, level_nx;
        logic [HOLD_W-1:0] hold, hold_nx;
        logic [1:0]        phase, phase_nx;
        logic [7:0]        pos_r, pos_nx;
        logic              step, step_nx;

        always_ff @(posedge CLK) begin
            if (reset) begin
                l_q   <= 1'b0;
                r_q   <= 1'b0;
                state <= IDLE;
                cnt   <= '0;
                level <= '0;
                hold  <= '0;
                phase <= 2'b00;
                pos_r <= 8'd0;
                step  <= 1'b0;
            end else begin
                l_q   <= bus.left[n];
                r_q   <= bus.right[n];
                state <= state_nx;
                cnt   <= cnt_nx;
                level <= level_nx;
                hold  <= hold_nx;
                phase <= phase_nx;
                pos_r <= pos_nx;
                step  <= step_nx;
            end
        end

        always_comb begin
            state_nx = IDLE;
            cnt_nx   = cnt;
            level_nx = level;
            hold_nx  = hold;
            phase_nx = phase;
            pos_nx   = pos_r;
            step_nx  = 1'b0;

            // A zero period (clkdiv=0 or fully shifted out) still means one step per cycle.
            eff    = bus.accel_en ? (bus.clkdiv >> level) : bus.clkdiv;
            per_m1 = (eff == '0) ? '0 : eff - 1'b1;

            if (r_q && !l_q)      state_nx = RUN_R;
            else if (l_q && !r_q) state_nx = RUN_L;

            if (state_nx != state || state == IDLE) begin
                cnt_nx   = '0;
                level_nx = '0;
                hold_nx  = '0;
            end else if (cnt >= per_m1) begin
                cnt_nx  = '0;
                step_nx = 1'b1;
                if (state == RUN_R) begin
                    pos_nx = pos_r + 8'd1;
                    case (phase)
                        2'b00:   phase_nx = 2'b01;
                        2'b01:   phase_nx = 2'b11;
                        2'b11:   phase_nx = 2'b10;
                        default: phase_nx = 2'b00;
                    endcase
                end else begin
                    pos_nx = pos_r - 8'd1;
                    case (phase)
                        2'b00:   phase_nx = 2'b10;
                        2'b10:   phase_nx = 2'b11;
                        2'b11:   phase_nx = 2'b01;
                        default: phase_nx = 2'b00;
                    endcase
                end
                // hold saturates at the top level instead of wrapping.
                if (bus.accel_en) begin
                    if (hold >= HOLD_MAX - 1'b1) begin
                        if (level < TOP_LVL) begin
                            level_nx = level + 1'b1;
                            hold_nx  = '0;
                        end else begin
                            hold_nx  = HOLD_MAX;
                        end
                    end else begin
                        hold_nx = hold + 1'b1;
                    end
                end
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end

        assign phase_a[n] = phase;
        assign pos_a[n]   = pos_r;
        assign state_a[n] = state;
        assign step_a[n]  = step;
    end

    assign bus.steer      = phase_a;
    assign bus.pos        = pos_a;
    assign bus.state_dbg  = state_a;
    assign bus.step_pulse = step_a;
endmodule
